// File: rtl/branch_history_table_if.sv
// ---------------------------------------------------------------------------
// branch_history_table_if
//
// Bundles the fetch-side lookup port and the resolve-side update port of the
// branch history table.
//
//   pred_pc          fetch PC to predict                (pipeline -> table)
//   pred_taken       predicted direction                (table -> pipeline)
//   pred_idx         table index used for the lookup    (table -> pipeline)
//   upd_valid        resolve-stage update strobe        (pipeline -> table)
//   upd_idx          index captured at prediction time  (pipeline -> table)
//   upd_taken        actual branch outcome              (pipeline -> table)
//   upd_mispredict   resolved direction was mispredicted (pipeline -> table)
//   ready            init sweep finished                (table -> pipeline)
//   mispredict_count saturating mispredict statistic    (table -> pipeline)
//
// master: the pipeline side. slave: the table itself.
// ---------------------------------------------------------------------------
interface branch_history_table_if #(
  parameter int INDEX_BITS = 6
);

  logic [31:0]           pred_pc;
  logic                  pred_taken;
  logic [INDEX_BITS-1:0] pred_idx;
  logic                  upd_valid;
  logic [INDEX_BITS-1:0] upd_idx;
  logic                  upd_taken;
  logic                  upd_mispredict;
  logic                  ready;
  logic [31:0]           mispredict_count;

  modport master (
    output pred_pc, upd_valid, upd_idx, upd_taken, upd_mispredict,
    input  pred_taken, pred_idx, ready, mispredict_count
  );

  modport slave (
    input  pred_pc, upd_valid, upd_idx, upd_taken, upd_mispredict,
    output pred_taken, pred_idx, ready, mispredict_count
  );

endinterface

// File: rtl/branch_history_table.sv
// ---------------------------------------------------------------------------
// branch_history_table
//
// Table of 2^INDEX_BITS saturating CTR_BITS-wide branch-direction counters
// with an optional gshare hash (GHR_BITS > 0) of the fetch PC with a global
// history register that is only updated when branches resolve.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    branch_history_table_if.slave (lookup port, update port, ready,
//          mispredict_count)
//
// After reset the table is walked one entry per cycle writing weak
// not-taken, so the counter storage itself never needs a reset. Lookups are
// combinational (read-before-write against a same-cycle update).
// ---------------------------------------------------------------------------
module branch_history_table #(
  parameter int INDEX_BITS = 6,
  parameter int CTR_BITS   = 2,
  parameter int GHR_BITS   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  branch_history_table_if.slave   bus
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  // Keep the history register at least one bit wide so bimodal builds still
  // elaborate; in that case it simply stays zero.
  localparam int GHR_W   = (GHR_BITS > 0) ? GHR_BITS : 1;

  localparam logic [CTR_BITS-1:0] WNT     = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t                state;
  logic [INDEX_BITS-1:0] init_ptr;
  logic [GHR_W-1:0]      ghr;
  logic [GHR_W-1:0]      ghr_next;
  logic                  ready_q;
  logic [31:0]           misp_cnt;

  // Counter storage: no reset, async read, single write port.
  logic [CTR_BITS-1:0]   ctr_mem [ENTRIES];

  logic [INDEX_BITS-1:0] base_idx;
  logic [INDEX_BITS-1:0] hash_idx;
  logic [CTR_BITS-1:0]   upd_cur;
  logic [CTR_BITS-1:0]   upd_next;
  logic                  unused_bits;

  assign base_idx = bus.pred_pc[INDEX_BITS+1:2];

  // Index hash: plain PC bits, or PC bits XOR zero-extended history.
  generate
    if (GHR_BITS == 0) begin : g_bimodal
      assign hash_idx = base_idx;
    end else begin : g_gshare
      assign hash_idx = base_idx ^ INDEX_BITS'(ghr);
    end
  endgenerate

  // History shift on resolve; newest outcome enters at bit 0.
  generate
    if (GHR_BITS == 0) begin : g_no_hist
      assign ghr_next = '0;
    end else if (GHR_BITS == 1) begin : g_hist1
      assign ghr_next = bus.upd_taken;
    end else begin : g_histn
      assign ghr_next = {ghr[GHR_W-2:0], bus.upd_taken};
    end
  endgenerate

  // Prediction is masked during the sweep because entries are still garbage.
  assign bus.pred_idx         = hash_idx;
  assign bus.pred_taken       = (state == ST_RUN) && ctr_mem[hash_idx][CTR_BITS-1];
  assign bus.ready            = ready_q;
  assign bus.mispredict_count = misp_cnt;

  assign unused_bits = ^{bus.pred_pc[31:INDEX_BITS+2], bus.pred_pc[1:0], ghr};

  // Saturating step of the counter addressed by the update port.
  always_comb begin
    upd_cur  = ctr_mem[bus.upd_idx];
    upd_next = upd_cur;
    if (bus.upd_taken) begin
      if (upd_cur != CTR_MAX) upd_next = upd_cur + CTR_BITS'(1);
    end else begin
      if (upd_cur != '0) upd_next = upd_cur - CTR_BITS'(1);
    end
  end

  // Counter storage write port: shared between the init sweep and the
  // resolve-stage update, which can never be active in the same cycle.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == ST_INIT) begin
        ctr_mem[init_ptr] <= WNT;
      end else if (bus.upd_valid) begin
        ctr_mem[bus.upd_idx] <= upd_next;
      end
    end
  end

  // Control state: sweep pointer, ready flag, history and mispredict
  // statistics. ready is set on the same edge that writes the last entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_INIT;
      init_ptr <= '0;
      ghr      <= '0;
      misp_cnt <= '0;
      ready_q  <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          init_ptr <= init_ptr + INDEX_BITS'(1);
          if (init_ptr == INDEX_BITS'(ENTRIES - 1)) begin
            state   <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.upd_valid) begin
            ghr <= ghr_next;
            if (bus.upd_mispredict && (misp_cnt != 32'hFFFF_FFFF)) begin
              misp_cnt <= misp_cnt + 32'd1;
            end
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_history_table.sv
// ---------------------------------------------------------------------------
// tb_branch_history_table
//
// Directed bench for branch_history_table. Three instances share one clock:
//   dut_a  INDEX_BITS=4, CTR_BITS=2, GHR_BITS=0  (sweep, saturation, bypass)
//   dut_b  INDEX_BITS=4, CTR_BITS=3, GHR_BITS=0  (wider counters)
//   dut_c  INDEX_BITS=6, CTR_BITS=2, GHR_BITS=4  (gshare, stats, mid-run reset)
// Inputs change and outputs are sampled 1-2 time units after the rising edge.
// ---------------------------------------------------------------------------
module tb_branch_history_table;

  logic clk;
  logic rst_n_a, rst_n_b, rst_n_c;
  int   checks;
  int   errors;

  branch_history_table_if #(.INDEX_BITS(4)) bus_a ();
  branch_history_table_if #(.INDEX_BITS(4)) bus_b ();
  branch_history_table_if #(.INDEX_BITS(6)) bus_c ();

  branch_history_table #(.INDEX_BITS(4), .CTR_BITS(2), .GHR_BITS(0)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .bus(bus_a)
  );
  branch_history_table #(.INDEX_BITS(4), .CTR_BITS(3), .GHR_BITS(0)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .bus(bus_b)
  );
  branch_history_table #(.INDEX_BITS(6), .CTR_BITS(2), .GHR_BITS(4)) dut_c (
    .clk(clk), .rst_n(rst_n_c), .bus(bus_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one update on each instance for a single edge.
  task automatic upd_a(input logic [3:0] idx, input logic taken, input logic misp);
    bus_a.upd_valid = 1'b1; bus_a.upd_idx = idx;
    bus_a.upd_taken = taken; bus_a.upd_mispredict = misp;
    @(posedge clk); #1;
    bus_a.upd_valid = 1'b0; bus_a.upd_mispredict = 1'b0;
  endtask

  task automatic upd_b(input logic [3:0] idx, input logic taken);
    bus_b.upd_valid = 1'b1; bus_b.upd_idx = idx;
    bus_b.upd_taken = taken; bus_b.upd_mispredict = 1'b0;
    @(posedge clk); #1;
    bus_b.upd_valid = 1'b0;
  endtask

  task automatic upd_c(input logic [5:0] idx, input logic taken, input logic misp);
    bus_c.upd_valid = 1'b1; bus_c.upd_idx = idx;
    bus_c.upd_taken = taken; bus_c.upd_mispredict = misp;
    @(posedge clk); #1;
    bus_c.upd_valid = 1'b0; bus_c.upd_mispredict = 1'b0;
  endtask

  // Reset/sweep timing of dut_a, with pred_taken masked and updates ignored
  // during INIT; dut_b and dut_c are released at the same time.
  task automatic test_reset();
    rst_n_a = 1'b0; rst_n_b = 1'b0; rst_n_c = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #1;
    checks++;
    if (bus_a.ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got %b exp 0", bus_a.ready); end
    checks++;
    if (bus_a.mispredict_count !== 32'd0) begin errors++; $display("[TB] FAIL reset_count got %0d exp 0", bus_a.mispredict_count); end
    rst_n_a = 1'b1; rst_n_b = 1'b1; rst_n_c = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      bus_a.pred_pc = 32'hABC0_0003 | 32'((k - 1) * 4);
      if (k >= 10) begin
        bus_a.upd_valid = 1'b1; bus_a.upd_idx = 4'd0;
        bus_a.upd_taken = 1'b1; bus_a.upd_mispredict = 1'b1;
      end
      #1;
      checks++;
      if (bus_a.ready !== 1'b0) begin errors++; $display("[TB] FAIL init_ready cyc %0d got %b exp 0", k, bus_a.ready); end
      checks++;
      if (bus_a.pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL init_pred cyc %0d got %b exp 0", k, bus_a.pred_taken); end
      checks++;
      if (bus_a.pred_idx !== 4'(k - 1)) begin errors++; $display("[TB] FAIL init_idx cyc %0d got %0h exp %0h", k, bus_a.pred_idx, k - 1); end
      @(posedge clk); #1;
    end
    bus_a.upd_valid = 1'b0; bus_a.upd_mispredict = 1'b0;
    bus_a.pred_pc = 32'h0;
    #1;
    checks++;
    if (bus_a.ready !== 1'b1) begin errors++; $display("[TB] FAIL ready_cyc17 got %b exp 1", bus_a.ready); end
    checks++;
    if (bus_a.mispredict_count !== 32'd0) begin errors++; $display("[TB] FAIL init_ignored_count got %0d exp 0", bus_a.mispredict_count); end
    checks++;
    if (bus_a.pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL init_ignored_ctr got %b exp 0", bus_a.pred_taken); end
  endtask

  // 2-bit counter at idx 5: up to 3 and hold, then down to 0 and hold.
  task automatic test_saturation();
    logic [7:0] taken_seq;
    logic [7:0] exp_pred;
    taken_seq = 8'b0000_1111;
    exp_pred  = 8'b0001_1111;
    bus_a.pred_pc = 32'h14;
    #1;
    checks++;
    if (bus_a.pred_idx !== 4'd5) begin errors++; $display("[TB] FAIL sat_idx got %0h exp 5", bus_a.pred_idx); end
    checks++;
    if (bus_a.pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL sat_start got %b exp 0", bus_a.pred_taken); end
    for (int i = 0; i < 8; i++) begin
      upd_a(4'd5, taken_seq[i], 1'b0);
      checks++;
      if (bus_a.pred_taken !== exp_pred[i]) begin
        errors++; $display("[TB] FAIL sat_step %0d got %b exp %b", i, bus_a.pred_taken, exp_pred[i]);
      end
    end
  endtask

  // Lookup and taken update to idx 7 in the same cycle: old value first.
  task automatic test_same_cycle();
    bus_a.pred_pc = 32'h1C;
    bus_a.upd_valid = 1'b1; bus_a.upd_idx = 4'd7;
    bus_a.upd_taken = 1'b1; bus_a.upd_mispredict = 1'b0;
    #1;
    checks++;
    if (bus_a.pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL same_cycle_old got %b exp 0", bus_a.pred_taken); end
    @(posedge clk); #1;
    bus_a.upd_valid = 1'b0;
    #1;
    checks++;
    if (bus_a.pred_taken !== 1'b1) begin errors++; $display("[TB] FAIL same_cycle_new got %b exp 1", bus_a.pred_taken); end
  endtask

  // 3-bit counters start at 3; step across the 3/4 taken boundary.
  task automatic test_ctr3();
    int n;
    n = 0;
    while (bus_b.ready !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    checks++;
    if (bus_b.ready !== 1'b1) begin errors++; $display("[TB] FAIL ctr3_ready got %b exp 1", bus_b.ready); end
    for (int e = 0; e < 16; e++) begin
      bus_b.pred_pc = 32'(e * 4);
      #1;
      checks++;
      if (bus_b.pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL ctr3_init idx %0d got %b exp 0", e, bus_b.pred_taken); end
    end
    upd_b(4'd4, 1'b1);
    bus_b.pred_pc = 32'h10;
    #1;
    checks++;
    if (bus_b.pred_taken !== 1'b1) begin errors++; $display("[TB] FAIL ctr3_3to4 got %b exp 1", bus_b.pred_taken); end
    bus_b.pred_pc = 32'h18;
    upd_b(4'd6, 1'b0);
    checks++;
    if (bus_b.pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL ctr3_3to2 got %b exp 0", bus_b.pred_taken); end
    upd_b(4'd6, 1'b1);
    checks++;
    if (bus_b.pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL ctr3_2to3 got %b exp 0", bus_b.pred_taken); end
    upd_b(4'd6, 1'b1);
    checks++;
    if (bus_b.pred_taken !== 1'b1) begin errors++; $display("[TB] FAIL ctr3_3to4b got %b exp 1", bus_b.pred_taken); end
  endtask

  // gshare: T,T,N on idx 0 gives ghr 0110; pc 0x40 hashes to 0x16.
  task automatic test_gshare();
    int n;
    n = 0;
    while (bus_c.ready !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    checks++;
    if (bus_c.ready !== 1'b1) begin errors++; $display("[TB] FAIL gshare_ready got %b exp 1", bus_c.ready); end
    bus_c.pred_pc = 32'h40;
    #1;
    checks++;
    if (bus_c.pred_idx !== 6'h10) begin errors++; $display("[TB] FAIL gshare_idx0 got %0h exp 10", bus_c.pred_idx); end
    upd_c(6'd0, 1'b1, 1'b0);
    checks++;
    if (bus_c.pred_idx !== 6'h11) begin errors++; $display("[TB] FAIL gshare_idx1 got %0h exp 11", bus_c.pred_idx); end
    upd_c(6'd0, 1'b1, 1'b0);
    checks++;
    if (bus_c.pred_idx !== 6'h13) begin errors++; $display("[TB] FAIL gshare_idx2 got %0h exp 13", bus_c.pred_idx); end
    bus_c.upd_valid = 1'b1; bus_c.upd_idx = 6'd0;
    bus_c.upd_taken = 1'b0; bus_c.upd_mispredict = 1'b0;
    #1;
    checks++;
    if (bus_c.pred_idx !== 6'h13) begin errors++; $display("[TB] FAIL gshare_old_ghr got %0h exp 13", bus_c.pred_idx); end
    @(posedge clk); #1;
    bus_c.upd_valid = 1'b0;
    #1;
    checks++;
    if (bus_c.pred_idx !== 6'h16) begin errors++; $display("[TB] FAIL gshare_idx3 got %0h exp 16", bus_c.pred_idx); end
    bus_c.pred_pc = 32'h18;
    #1;
    checks++;
    if (bus_c.pred_idx !== 6'h00) begin errors++; $display("[TB] FAIL gshare_idx_e0 got %0h exp 0", bus_c.pred_idx); end
    checks++;
    if (bus_c.pred_taken !== 1'b1) begin errors++; $display("[TB] FAIL gshare_ctr0 got %b exp 1", bus_c.pred_taken); end
  endtask

  // Five mispredicts (plus one ignored strobe), then a mid-run reset pulse.
  task automatic test_mispredict_reset();
    for (int i = 0; i < 5; i++) begin
      upd_c(6'h2A, 1'b1, 1'b1);
      if (i == 2) begin
        bus_c.upd_valid = 1'b0; bus_c.upd_mispredict = 1'b1;
        @(posedge clk); #1;
        bus_c.upd_mispredict = 1'b0;
      end
    end
    #1;
    checks++;
    if (bus_c.mispredict_count !== 32'd5) begin errors++; $display("[TB] FAIL misp_count got %0d exp 5", bus_c.mispredict_count); end
    rst_n_c = 1'b0;
    @(posedge clk); #1;
    rst_n_c = 1'b1;
    bus_c.pred_pc = 32'h40;
    #1;
    checks++;
    if (bus_c.mispredict_count !== 32'd0) begin errors++; $display("[TB] FAIL rerst_count got %0d exp 0", bus_c.mispredict_count); end
    checks++;
    if (bus_c.pred_idx !== 6'h10) begin errors++; $display("[TB] FAIL rerst_ghr_idx got %0h exp 10", bus_c.pred_idx); end
    for (int k = 1; k <= 64; k++) begin
      checks++;
      if (bus_c.ready !== 1'b0) begin errors++; $display("[TB] FAIL rerst_ready cyc %0d got %b exp 0", k, bus_c.ready); end
      checks++;
      if (bus_c.pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL rerst_pred cyc %0d got %b exp 0", k, bus_c.pred_taken); end
      @(posedge clk); #1;
    end
    checks++;
    if (bus_c.ready !== 1'b1) begin errors++; $display("[TB] FAIL rerst_ready_end got %b exp 1", bus_c.ready); end
    for (int e = 0; e < 64; e++) begin
      bus_c.pred_pc = 32'(e * 4);
      #1;
      checks++;
      if (bus_c.pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL rerst_entry %0d got %b exp 0", e, bus_c.pred_taken); end
    end
    upd_c(6'h2A, 1'b1, 1'b0);
    bus_c.pred_pc = 32'hAC;
    #1;
    checks++;
    if (bus_c.pred_idx !== 6'h2A) begin errors++; $display("[TB] FAIL rerst_hash got %0h exp 2a", bus_c.pred_idx); end
    checks++;
    if (bus_c.pred_taken !== 1'b1) begin errors++; $display("[TB] FAIL rerst_wnt got %b exp 1", bus_c.pred_taken); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n_a = 1'b0; rst_n_b = 1'b0; rst_n_c = 1'b0;
    bus_a.pred_pc = '0; bus_a.upd_valid = 1'b0; bus_a.upd_idx = '0;
    bus_a.upd_taken = 1'b0; bus_a.upd_mispredict = 1'b0;
    bus_b.pred_pc = '0; bus_b.upd_valid = 1'b0; bus_b.upd_idx = '0;
    bus_b.upd_taken = 1'b0; bus_b.upd_mispredict = 1'b0;
    bus_c.pred_pc = '0; bus_c.upd_valid = 1'b0; bus_c.upd_idx = '0;
    bus_c.upd_taken = 1'b0; bus_c.upd_mispredict = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_saturation();
    test_same_cycle();
    test_ctr3();
    test_gshare();
    test_mispredict_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout exp finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/branch_history_table.md
Name: branch_history_table

Overview:
Parametrised table of N-bit saturating branch-direction counters. It supersedes the single-entry 2-bit predictor FSM with a configurable-depth, configurable-width table and an optional gshare global-history index hash. The IF stage uses a combinational lookup port. The EX stage uses a registered update port when a branch resolves. After reset, a built-in init sweep clears the table without a wide reset fan-out, and a saturating mispredict counter provides performance statistics.

Parameters:
INDEX_BITS, 6, log2 of entry count (ENTRIES = 2^INDEX_BITS); legal range 2..12
CTR_BITS, 2, width of each saturating counter; legal range 2..4
GHR_BITS, 0, global history length; 0 selects bimodal indexing; legal range 0..INDEX_BITS

Ports:
clk  in  1  clock; all state changes on its rising edge
rst_n  in  1  synchronous, active-low reset
pred_pc  in  32  fetch PC to predict
pred_taken  out  1  predicted direction (MSB of the indexed counter)
pred_idx  out  INDEX_BITS  table index used; carried down the pipe and returned on upd_idx
upd_valid  in  1  resolve-stage update strobe
upd_idx  in  INDEX_BITS  index captured at prediction time
upd_taken  in  1  actual branch outcome
upd_mispredict  in  1  resolved direction differed from prediction
ready  out  1  high once the init sweep has completed
mispredict_count  out  32  saturating count of mispredicts

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state <= INIT, init_ptr <= 0, ghr <= 0, mispredict_count <= 0, ready <= 0.
  - Counter contents are don't-care until the sweep rewrites them.
- INIT state:
  - Each cycle with rst_n=1, table[init_ptr] <= WNT, where WNT = 2^(CTR_BITS-1)-1 (weak not-taken), and init_ptr increments.
  - The cycle that writes entry ENTRIES-1 moves the state to RUN. ready becomes 1 in the next cycle.
  - Init latency is exactly ENTRIES cycles after rst_n deasserts.
  - During INIT: pred_taken forced to 0; upd_valid ignored (no table, ghr or counter change); pred_idx still computed.
  - Reset asserted during INIT restarts the sweep from 0.
- RUN state:
  - Stays in RUN until rst_n=0. Reset mid-RUN returns to INIT and repeats the full sweep.
- Index hash (combinational):
  - base = pred_pc[INDEX_BITS+1:2].
  - GHR_BITS=0: pred_idx = base.
  - Otherwise: pred_idx = base XOR {zeros, ghr[GHR_BITS-1:0]} (ghr zero-extended into the low bits).
- Prediction:
  - pred_taken = table[pred_idx][CTR_BITS-1], combinational, zero latency.
- Update (RUN and upd_valid=1, applied at the clk edge):
  - upd_taken=1: counter <= min(counter+1, 2^CTR_BITS-1).
  - upd_taken=0: counter <= max(counter-1, 0).
  - No wrap in either direction.
  - When GHR_BITS>0: ghr <= {ghr[GHR_BITS-2:0], upd_taken}. For GHR_BITS=1: ghr <= upd_taken.
  - ghr is updated only at resolve; there is no speculative history.
  - upd_mispredict=1: mispredict_count increments, holding at 0xFFFFFFFF.
  - upd_mispredict is ignored when upd_valid=0.
- Same-cycle lookup and update to the same index:
  - pred_taken reflects the pre-update counter value (read-before-write, no bypass).
  - The update is visible on the following cycle.
  - A lookup in the same cycle as a ghr update hashes with the old ghr.
- Only one update port exists; there is no collision case to arbitrate.
- Storage may be flops or inferred distributed RAM with an asynchronous read. It must have no reset port; only the sweep initialises it.

Test Plan:
- INDEX_BITS=4: hold rst_n=0 for 3 cycles, then release.
  -> ready=0 for exactly 16 cycles, 1 on cycle 17. pred_taken=0 for every PC throughout.
- CTR_BITS=2, GHR_BITS=0, after ready: three taken updates to idx 5.
  -> counter 1→2→3; pred_taken for pc 0x14 becomes 1 after the first update. A fourth taken update leaves it at 3.
  -> Then four not-taken updates: 3→2→1→0→0; pred_taken becomes 0 after the second.
- CTR_BITS=3: reset.
  -> every entry reads 3 (pred_taken=0). One taken update gives 4 (pred_taken=1).
- GHR_BITS=4, INDEX_BITS=6: resolve updates taken, taken, not-taken on idx 0.
  -> ghr=0b0110. pred_pc=0x40 gives pred_idx = 0x10 XOR 0x6 = 0x16.
- Same-cycle lookup and taken update on idx 7, with counter at 1.
  -> pred_taken=0 that cycle, 1 the next cycle.
- Five mispredict updates, then rst_n pulsed low mid-RUN.
  -> mispredict_count=5 before the pulse. After it: count=0, ghr=0, ready=0 for ENTRIES cycles, and every entry reads back WNT.
